spi_reg_ctrl: RTL and testbench
===============================

SPI_REG_CTRL -- requirements
Module: spi_reg_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 8: SPI byte width and register data width.
REQ-002 SHALL have parameter ADDR_W, default 7: register address width, equal to DATA_W-1.
REQ-003 SHALL have parameter ACK_TIMEOUT, default 16: maximum cycles from read request to i_reg_ack.
REQ-004 SHALL have port i_clk, input, 1 bit: the only clock; all logic is rising-edge.
REQ-005 SHALL have port i_rst_n, input, 1 bit: synchronous, active-low reset.
REQ-006 SHALL have port i_rx_data, input, DATA_W bits: byte received from the SPI slave.
REQ-007 SHALL have port i_rx_valid, input, 1 bit: one-cycle pulse qualifying i_rx_data.
REQ-008 SHALL have port i_spi_busy, input, 1 bit: high while chip-select is asserted (frame active).
REQ-009 SHALL have port o_tx_data, output, DATA_W bits: byte for the slave's next MISO shift.
REQ-010 SHALL have port o_tx_valid, output, 1 bit: one-cycle load strobe for o_tx_data.
REQ-011 SHALL have port i_tx_ready, input, 1 bit: the slave can accept o_tx_data.
REQ-012 SHALL have port o_reg_addr, output, ADDR_W bits: register address.
REQ-013 SHALL have port o_reg_wdata, output, DATA_W bits: register write data.
REQ-014 SHALL have port o_reg_wr, output, 1 bit: one-cycle write strobe.
REQ-015 SHALL have port o_reg_rd, output, 1 bit: read request, held until ack or timeout.
REQ-016 SHALL have port i_reg_rdata, input, DATA_W bits: read data, valid with i_reg_ack.
REQ-017 SHALL have port i_reg_ack, input, 1 bit: read completion.
REQ-018 SHALL have port o_err, output, 1 bit: one-cycle pulse on read timeout or tx overrun.

Function
REQ-019 SHALL implement states IDLE, CMD, WR_DATA, RD_REQ, RD_WAIT, RD_LOAD and RD_STREAM.
- IDLE -> CMD on the rising edge of i_spi_busy.
- On entry to CMD, load STATUS_BYTE (0x5A) when i_tx_ready.
REQ-020 SHALL decode the first byte of a frame in CMD as follows:
- bit[DATA_W-1] = 1 means read, 0 means write.
- bits[ADDR_W-1:0] give the start address, latched into o_reg_addr.
- Write -> WR_DATA. Read -> RD_REQ.
REQ-021 SHALL, in WR_DATA, pulse o_reg_wr with o_reg_wdata = i_rx_data exactly one cycle after each i_rx_valid, then increment the address.
REQ-022 SHALL, in RD_REQ/RD_WAIT, assert o_reg_rd until i_reg_ack; on ack, capture i_reg_rdata and go to RD_LOAD.
REQ-023 SHALL, in RD_LOAD, wait for i_tx_ready, pulse o_tx_valid with the captured data, increment the address, then go to RD_STREAM.
REQ-024 SHALL, in RD_STREAM, treat each i_rx_valid (dummy byte) as a trigger to go to RD_REQ and prefetch the next address.
REQ-025 SHALL wrap address increments modulo 2^ADDR_W (0x7F -> 0x00).
REQ-026 SHALL handle a read timeout (ACK_TIMEOUT cycles in RD_WAIT without ack) as follows:
- deassert o_reg_rd;
- pulse o_err;
- load 0xFF as the tx byte;
- continue to RD_LOAD.
REQ-027 SHALL pulse o_err when i_rx_valid arrives in RD_REQ/RD_WAIT/RD_LOAD, i.e. the master clocked faster than the prefetch.
REQ-028 SHALL, on the falling edge of i_spi_busy in any state, return to IDLE next cycle:
- o_reg_rd drops;
- a late i_reg_ack is ignored;
- no o_reg_wr is issued for a partial byte.
REQ-029 SHALL give priority to frame end when frame end and i_rx_valid occur in the same cycle; a write byte already validated in that cycle is still written.
REQ-030 SHALL keep all outputs registered, with no combinational path from any input to any output.

Reset
REQ-031 SHALL, while i_rst_n = 0 at a clock edge, set:
- state to IDLE;
- o_tx_data = 0, o_tx_valid = 0;
- o_reg_addr = 0, o_reg_wdata = 0;
- o_reg_wr = 0, o_reg_rd = 0;
- o_err = 0;
- timeout counter = 0.
REQ-032 SHALL, on reset mid-frame, abandon the frame; after release, the FSM waits for a fresh rising edge of i_spi_busy.

Structure
REQ-033 SHALL place the state enum, STATUS_BYTE, the RD_BIT index and the timeout fill value 0xFF in shared package spi_reg_pkg.
REQ-034 SHALL contain no sub-modules; it is a single FSM with an address counter and a timeout counter, and edge detection on i_spi_busy is internal.

Verification
REQ-035 SHALL verify a write burst: frame 0x10,0xAA,0xBB -> o_reg_wr pulses at addr 0x10 data 0xAA, then 0x11 data 0xBB; no o_reg_rd.
REQ-036 SHALL verify a read burst: frame 0x85 plus 2 dummies, regfile 0x05=0x3C, 0x06=0xC3 -> MISO returns 0x5A,0x3C,0xC3; o_reg_rd seen at 0x05, 0x06, 0x07.
REQ-037 SHALL verify wrap-around: write frame 0x7F,0x11,0x22 -> writes at 0x7F then 0x00.
REQ-038 SHALL verify read timeout: ack withheld on read 0x82 -> o_err pulses after 16 cycles and master receives 0xFF.
REQ-039 SHALL verify abort: CS deasserted mid-byte during read prefetch -> IDLE next cycle, o_reg_rd low, a late ack ignored; the next frame works normally.
REQ-040 SHALL verify reset mid-frame: i_rst_n low during WR_DATA -> all outputs zero; no write is issued until a new frame.

Source files
------------

// File: rtl/spi_reg_pkg.sv
// Shared definitions for the SPI register-access controller: FSM states,
// the status byte sent while the command shifts in, and the read-timeout fill.
package spi_reg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    WR_DATA,
    RD_REQ,
    RD_WAIT,
    RD_LOAD,
    RD_STREAM
  } state_t;

  localparam logic [7:0] STATUS_BYTE  = 8'h5A;
  localparam logic [7:0] TIMEOUT_FILL = 8'hFF;
  localparam int         RD_BIT       = 7;

endpackage

// File: rtl/spi_reg_ctrl.sv
// Bridges an SPI slave byte stream to a simple register bus: first byte is
// R/W + start address, then auto-incrementing write data or prefetched reads.
module spi_reg_ctrl
  import spi_reg_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 7,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DATA_W-1:0] i_rx_data,
  input  logic              i_rx_valid,
  input  logic              i_spi_busy,
  output logic [DATA_W-1:0] o_tx_data,
  output logic              o_tx_valid,
  input  logic              i_tx_ready,
  output logic [ADDR_W-1:0] o_reg_addr,
  output logic [DATA_W-1:0] o_reg_wdata,
  output logic              o_reg_wr,
  output logic              o_reg_rd,
  input  logic [DATA_W-1:0] i_reg_rdata,
  input  logic              i_reg_ack,
  output logic              o_err
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  state_t            state_reg, state_next;
  logic              busy_q_reg;
  logic              status_pend_reg, status_pend_next;
  logic [DATA_W-1:0] tx_data_reg, tx_data_next;
  logic              tx_valid_reg, tx_valid_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic              wr_reg, wr_next;
  logic              rd_reg, rd_next;
  logic              err_reg, err_next;
  logic [TW-1:0]     timer_reg, timer_next;
  logic [DATA_W-1:0] rdata_reg, rdata_next;

  logic busy_rise;
  logic busy_fall;

  assign busy_rise = i_spi_busy & ~busy_q_reg;
  assign busy_fall = ~i_spi_busy & busy_q_reg;

  always_comb begin
    state_next       = state_reg;
    status_pend_next = status_pend_reg;
    tx_data_next     = tx_data_reg;
    tx_valid_next    = 1'b0;
    addr_next        = addr_reg;
    wdata_next       = wdata_reg;
    wr_next          = 1'b0;
    rd_next          = rd_reg;
    err_next         = 1'b0;
    timer_next       = timer_reg;
    rdata_next       = rdata_reg;

    // Address advances the cycle after each write strobe, so the strobe
    // always carries the address it was issued for.
    if (wr_reg) begin
      addr_next = addr_reg + ADDR_W'(1);
    end

    if (busy_fall && (state_reg != IDLE)) begin
      state_next       = IDLE;
      rd_next          = 1'b0;
      status_pend_next = 1'b0;
      if ((state_reg == WR_DATA) && i_rx_valid) begin
        wr_next    = 1'b1;
        wdata_next = i_rx_data;
      end
    end else begin
      case (state_reg)
        IDLE: begin
          if (busy_rise) begin
            state_next       = CMD;
            status_pend_next = 1'b1;
          end
        end

        CMD: begin
          if (status_pend_reg && i_tx_ready) begin
            tx_data_next     = DATA_W'(STATUS_BYTE);
            tx_valid_next    = 1'b1;
            status_pend_next = 1'b0;
          end
          if (i_rx_valid) begin
            addr_next        = i_rx_data[ADDR_W-1:0];
            status_pend_next = 1'b0;
            state_next       = i_rx_data[RD_BIT] ? RD_REQ : WR_DATA;
          end
        end

        WR_DATA: begin
          if (i_rx_valid) begin
            wr_next    = 1'b1;
            wdata_next = i_rx_data;
          end
        end

        RD_REQ: begin
          if (i_rx_valid) begin
            err_next = 1'b1;
          end
          rd_next    = 1'b1;
          timer_next = '0;
          state_next = RD_WAIT;
        end

        RD_WAIT: begin
          if (i_rx_valid) begin
            err_next = 1'b1;
          end
          if (i_reg_ack) begin
            rdata_next = i_reg_rdata;
            rd_next    = 1'b0;
            state_next = RD_LOAD;
          end else if (timer_reg == TW'(ACK_TIMEOUT - 1)) begin
            rdata_next = DATA_W'(TIMEOUT_FILL);
            rd_next    = 1'b0;
            err_next   = 1'b1;
            state_next = RD_LOAD;
          end else begin
            timer_next = timer_reg + TW'(1);
          end
        end

        RD_LOAD: begin
          if (i_rx_valid) begin
            err_next = 1'b1;
          end
          if (i_tx_ready) begin
            tx_data_next  = rdata_reg;
            tx_valid_next = 1'b1;
            addr_next     = addr_reg + ADDR_W'(1);
            state_next    = RD_STREAM;
          end
        end

        RD_STREAM: begin
          if (i_rx_valid) begin
            state_next = RD_REQ;
          end
        end

        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_reg       <= IDLE;
      // Treat the bus as busy out of reset so an already-open frame is not
      // mistaken for a new one.
      busy_q_reg      <= 1'b1;
      status_pend_reg <= 1'b0;
      tx_data_reg     <= '0;
      tx_valid_reg    <= 1'b0;
      addr_reg        <= '0;
      wdata_reg       <= '0;
      wr_reg          <= 1'b0;
      rd_reg          <= 1'b0;
      err_reg         <= 1'b0;
      timer_reg       <= '0;
      rdata_reg       <= '0;
    end else begin
      state_reg       <= state_next;
      busy_q_reg      <= i_spi_busy;
      status_pend_reg <= status_pend_next;
      tx_data_reg     <= tx_data_next;
      tx_valid_reg    <= tx_valid_next;
      addr_reg        <= addr_next;
      wdata_reg       <= wdata_next;
      wr_reg          <= wr_next;
      rd_reg          <= rd_next;
      err_reg         <= err_next;
      timer_reg       <= timer_next;
      rdata_reg       <= rdata_next;
    end
  end

  assign o_tx_data   = tx_data_reg;
  assign o_tx_valid  = tx_valid_reg;
  assign o_reg_addr  = addr_reg;
  assign o_reg_wdata = wdata_reg;
  assign o_reg_wr    = wr_reg;
  assign o_reg_rd    = rd_reg;
  assign o_err       = err_reg;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Frame-level directed bench for spi_reg_ctrl: a table of SPI frames with
// expected register traffic and MISO bytes, plus abort/reset/overrun sequences.
module tb_spi_reg_ctrl;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic [7:0] i_rx_data;
  logic       i_rx_valid;
  logic       i_spi_busy;
  logic [7:0] o_tx_data;
  logic       o_tx_valid;
  logic       i_tx_ready;
  logic [6:0] o_reg_addr;
  logic [7:0] o_reg_wdata;
  logic       o_reg_wr;
  logic       o_reg_rd;
  logic [7:0] i_reg_rdata;
  logic       i_reg_ack;
  logic       o_err;

  always #5 i_clk = ~i_clk;

  spi_reg_ctrl #(.DATA_W(8), .ADDR_W(7), .ACK_TIMEOUT(16)) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_rx_data  (i_rx_data),
    .i_rx_valid (i_rx_valid),
    .i_spi_busy (i_spi_busy),
    .o_tx_data  (o_tx_data),
    .o_tx_valid (o_tx_valid),
    .i_tx_ready (i_tx_ready),
    .o_reg_addr (o_reg_addr),
    .o_reg_wdata(o_reg_wdata),
    .o_reg_wr   (o_reg_wr),
    .o_reg_rd   (o_reg_rd),
    .i_reg_rdata(i_reg_rdata),
    .i_reg_ack  (i_reg_ack),
    .o_err      (o_err)
  );

  // Multi-byte fields are listed last element first (packed arrays).
  typedef struct packed {
    logic [2:0][7:0] bytes;
    int              nbytes;
    logic            ack_en;
    int              n_wr;
    logic [1:0][6:0] wr_addr;
    logic [1:0][7:0] wr_data;
    int              n_rd;
    logic [2:0][6:0] rd_addr;
    int              n_tx;
    logic [3:0][7:0] tx;
    int              n_err;
    int              err_lat;
  } vec_t;

  vec_t       vecs [5];
  vec_t       hv;
  logic [7:0] mem [128];
  logic [6:0] wr_addr_q [$];
  logic [7:0] wr_data_q [$];
  logic [6:0] rd_addr_q [$];
  logic [7:0] tx_q [$];
  int         err_cnt;
  int         cyc;
  int         rd_rise_cyc;
  int         err_cyc;
  logic       rd_prev;
  logic       ack_en;
  logic       late_ack;
  int         checks;
  int         errors;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: observe registered outputs just after the edge, then drive the
  // register-bus responder for the next edge.
  task automatic tick();
    @(posedge i_clk);
    #1;
    cyc++;
    if (o_reg_wr) begin
      wr_addr_q.push_back(o_reg_addr);
      wr_data_q.push_back(o_reg_wdata);
      mem[o_reg_addr] = o_reg_wdata;
    end
    if (o_reg_rd && !rd_prev) begin
      rd_addr_q.push_back(o_reg_addr);
      rd_rise_cyc = cyc;
    end
    rd_prev = o_reg_rd;
    if (o_tx_valid) tx_q.push_back(o_tx_data);
    if (o_err) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (late_ack) begin
      i_reg_ack   = 1'b1;
      i_reg_rdata = 8'hEE;
    end else if (ack_en && o_reg_rd && !i_reg_ack) begin
      i_reg_ack   = 1'b1;
      i_reg_rdata = mem[o_reg_addr];
    end else begin
      i_reg_ack = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] data, input int gap);
    repeat (gap) tick();
    i_rx_data  = data;
    i_rx_valid = 1'b1;
    tick();
    i_rx_valid = 1'b0;
  endtask

  task automatic clear_logs();
    wr_addr_q.delete();
    wr_data_q.delete();
    rd_addr_q.delete();
    tx_q.delete();
    err_cnt     = 0;
    rd_rise_cyc = 0;
    err_cyc     = 0;
  endtask

  task automatic run_frame(input vec_t v);
    clear_logs();
    ack_en     = v.ack_en;
    i_spi_busy = 1'b1;
    repeat (3) tick();
    for (int b = 0; b < v.nbytes; b++) send_byte(v.bytes[b], 7);
    repeat (30) tick();
    i_spi_busy = 1'b0;
    repeat (4) tick();
    ack_en = 1'b1;
  endtask

  task automatic check_frame(input string tag, input vec_t v);
    check({tag, " wr_count"}, wr_addr_q.size(), v.n_wr);
    for (int i = 0; i < v.n_wr; i++) begin
      check($sformatf("%s wr_addr[%0d]", tag, i), (i < wr_addr_q.size()) ? int'(wr_addr_q[i]) : -1, int'(v.wr_addr[i]));
      check($sformatf("%s wr_data[%0d]", tag, i), (i < wr_data_q.size()) ? int'(wr_data_q[i]) : -1, int'(v.wr_data[i]));
    end
    check({tag, " rd_count"}, rd_addr_q.size(), v.n_rd);
    for (int i = 0; i < v.n_rd; i++)
      check($sformatf("%s rd_addr[%0d]", tag, i), (i < rd_addr_q.size()) ? int'(rd_addr_q[i]) : -1, int'(v.rd_addr[i]));
    check({tag, " tx_count"}, tx_q.size(), v.n_tx);
    for (int i = 0; i < v.n_tx; i++)
      check($sformatf("%s tx[%0d]", tag, i), (i < tx_q.size()) ? int'(tx_q[i]) : -1, int'(v.tx[i]));
    check({tag, " err_count"}, err_cnt, v.n_err);
    if (v.err_lat != 0) check({tag, " err_latency"}, err_cyc - rd_rise_cyc, v.err_lat);
    $display("%s: writes=%0d reads=%0d tx=%0d err=%0d", tag, wr_addr_q.size(), rd_addr_q.size(), tx_q.size(), err_cnt);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, " o_tx_data"}, o_tx_data, 0);
    check({tag, " o_tx_valid"}, o_tx_valid, 0);
    check({tag, " o_reg_addr"}, o_reg_addr, 0);
    check({tag, " o_reg_wdata"}, o_reg_wdata, 0);
    check({tag, " o_reg_wr"}, o_reg_wr, 0);
    check({tag, " o_reg_rd"}, o_reg_rd, 0);
    check({tag, " o_err"}, o_err, 0);
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; rd_prev = 1'b0;
    ack_en = 1'b1; late_ack = 1'b0;
    i_rst_n = 1'b0; i_rx_data = '0; i_rx_valid = 1'b0; i_spi_busy = 1'b0;
    i_tx_ready = 1'b1; i_reg_rdata = '0; i_reg_ack = 1'b0;
    for (int i = 0; i < 128; i++) mem[i] = 8'h80 | 8'(i);
    mem[5] = 8'h3C;
    mem[6] = 8'hC3;
    clear_logs();

    vecs[0] = '{bytes: {8'hBB, 8'hAA, 8'h10}, nbytes: 3, ack_en: 1'b1,
                n_wr: 2, wr_addr: {7'h11, 7'h10}, wr_data: {8'hBB, 8'hAA},
                n_rd: 0, rd_addr: '0, n_tx: 1, tx: {8'h00, 8'h00, 8'h00, 8'h5A},
                n_err: 0, err_lat: 0};
    vecs[1] = '{bytes: {8'h00, 8'h00, 8'h85}, nbytes: 3, ack_en: 1'b1,
                n_wr: 0, wr_addr: '0, wr_data: '0,
                n_rd: 3, rd_addr: {7'h07, 7'h06, 7'h05}, n_tx: 4, tx: {8'h87, 8'hC3, 8'h3C, 8'h5A},
                n_err: 0, err_lat: 0};
    vecs[2] = '{bytes: {8'h22, 8'h11, 8'h7F}, nbytes: 3, ack_en: 1'b1,
                n_wr: 2, wr_addr: {7'h00, 7'h7F}, wr_data: {8'h22, 8'h11},
                n_rd: 0, rd_addr: '0, n_tx: 1, tx: {8'h00, 8'h00, 8'h00, 8'h5A},
                n_err: 0, err_lat: 0};
    vecs[3] = '{bytes: {8'h00, 8'h00, 8'h82}, nbytes: 1, ack_en: 1'b0,
                n_wr: 0, wr_addr: '0, wr_data: '0,
                n_rd: 1, rd_addr: {7'h00, 7'h00, 7'h02}, n_tx: 2, tx: {8'h00, 8'h00, 8'hFF, 8'h5A},
                n_err: 1, err_lat: 16};
    vecs[4] = '{bytes: {8'h00, 8'h00, 8'h80}, nbytes: 2, ack_en: 1'b1,
                n_wr: 0, wr_addr: '0, wr_data: '0,
                n_rd: 2, rd_addr: {7'h00, 7'h01, 7'h00}, n_tx: 3, tx: {8'h00, 8'h81, 8'h22, 8'h5A},
                n_err: 0, err_lat: 0};

    repeat (3) tick();
    check_outputs_zero("reset");
    i_rst_n = 1'b1;
    repeat (2) tick();

    for (int v = 0; v < 5; v++) begin
      run_frame(vecs[v]);
      check_frame($sformatf("frame%0d", v), vecs[v]);
    end

    // Abort while a read prefetch is outstanding, then a late ack.
    clear_logs();
    ack_en     = 1'b0;
    i_spi_busy = 1'b1;
    repeat (3) tick();
    send_byte(8'h85, 7);
    repeat (3) tick();
    check("abort rd_before", o_reg_rd, 1);
    i_spi_busy = 1'b0;
    tick();
    check("abort rd_after", o_reg_rd, 0);
    late_ack = 1'b1;
    tick();
    late_ack = 1'b0;
    repeat (4) tick();
    check("abort tx_count", tx_q.size(), 1);
    check("abort err_count", err_cnt, 0);
    check("abort o_reg_rd", o_reg_rd, 0);
    $display("abort: tx=%0d err=%0d", tx_q.size(), err_cnt);
    ack_en = 1'b1;
    hv = '{bytes: {8'h00, 8'h55, 8'h20}, nbytes: 2, ack_en: 1'b1,
           n_wr: 1, wr_addr: {7'h00, 7'h20}, wr_data: {8'h00, 8'h55},
           n_rd: 0, rd_addr: '0, n_tx: 1, tx: {8'h00, 8'h00, 8'h00, 8'h5A},
           n_err: 0, err_lat: 0};
    run_frame(hv);
    check_frame("after_abort", hv);

    // Reset in the middle of a write frame.
    clear_logs();
    i_spi_busy = 1'b1;
    repeat (3) tick();
    send_byte(8'h30, 7);
    repeat (3) tick();
    i_rst_n = 1'b0;
    tick();
    check_outputs_zero("midreset");
    i_rst_n = 1'b1;
    tick();
    send_byte(8'h66, 3);
    repeat (4) tick();
    check("midreset wr_count", wr_addr_q.size(), 0);
    check("midreset tx_count", tx_q.size(), 1);
    i_spi_busy = 1'b0;
    repeat (4) tick();
    $display("midreset: writes=%0d", wr_addr_q.size());
    hv = '{bytes: {8'h00, 8'h77, 8'h31}, nbytes: 2, ack_en: 1'b1,
           n_wr: 1, wr_addr: {7'h00, 7'h31}, wr_data: {8'h00, 8'h77},
           n_rd: 0, rd_addr: '0, n_tx: 1, tx: {8'h00, 8'h00, 8'h00, 8'h5A},
           n_err: 0, err_lat: 0};
    run_frame(hv);
    check_frame("after_reset", hv);

    // Dummy byte arriving before the prefetch completes.
    clear_logs();
    i_spi_busy = 1'b1;
    repeat (3) tick();
    send_byte(8'h81, 7);
    send_byte(8'h00, 0);
    repeat (30) tick();
    i_spi_busy = 1'b0;
    repeat (4) tick();
    check("overrun err_count", err_cnt, 1);
    check("overrun tx_count", tx_q.size(), 2);
    check("overrun tx[1]", (tx_q.size() > 1) ? int'(tx_q[1]) : -1, 8'h81);
    $display("overrun: tx=%0d err=%0d", tx_q.size(), err_cnt);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
